riscv_lsu: RTL and testbench

RISCV_LSU -- requirements
Module: riscv_lsu

---
 rtl/riscv_lsu_pkg.sv | 30 +++
 rtl/riscv_lsu_if.sv | 25 ++
 rtl/riscv_lsu_load_format.sv | 22 ++
 rtl/riscv_lsu.sv | 85 ++++++++
 tb/tb_riscv_lsu.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu_pkg: shared size codes, FSM state type and access-formatting helpers for the LSU.
// No ports; imported by riscv_lsu, lsu_load_format and the bench.
package riscv_lsu_pkg;
    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // Codes 3, 6 and 7 are not legal funct3 values and are trapped as misaligned.
    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
        return (size == LDST_B || size == LDST_BU) ? 1'b0 :
               (size == LDST_H || size == LDST_HU) ? off[0] :
               (size == LDST_W) ? (off != 2'b00) : 1'b1;
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] off);
        return (size == LDST_W) ? 4'b1111 :
               (size == LDST_H || size == LDST_HU) ? (off[1] ? 4'b1100 : 4'b0011) :
               4'b0001 << off;
    endfunction

    // Replicate the store operand across every lane so byte enables alone pick the target.
    function automatic logic [31:0] store_data(input logic [2:0] size, input logic [31:0] wd);
        return (size == LDST_W) ? wd :
               (size == LDST_H || size == LDST_HU) ? {2{wd[15:0]}} : {4{wd[7:0]}};
    endfunction
endpackage

// File: rtl/riscv_lsu_if.sv
// riscv_lsu_if: LSU-to-memory bus.
// master (LSU): drives mem_req_o, mem_we_o, mem_be_o, mem_addr_o (word aligned), mem_wd_o;
//               receives mem_rd_i (read word) and mem_ready_i (access completes this cycle).
// slave (memory): the mirror image.
interface riscv_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req_o;
    logic              mem_we_o;
    logic [3:0]        mem_be_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wd_o;
    logic [31:0]       mem_rd_i;
    logic              mem_ready_i;

    modport master (
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
        input  mem_rd_i, mem_ready_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
        output mem_rd_i, mem_ready_i
    );
endinterface

// File: rtl/riscv_lsu_load_format.sv
// lsu_load_format: extracts and extends a loaded byte/half/word from a little-endian memory word.
// Ports: word (memory word), off (byte address bits [1:0]), size (funct3 code) -> result (32-bit).
module lsu_load_format
    import riscv_lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  size,
    output logic [31:0] result
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = off == 2'd0 ? word[7:0] : off == 2'd1 ? word[15:8] : off == 2'd2 ? word[23:16] : word[31:24];
        h = off[1] ? word[31:16] : word[15:0];
        result = size == LDST_B  ? {{24{b[7]}}, b} :
                 size == LDST_BU ? {24'b0, b} :
                 size == LDST_H  ? {{16{h[15]}}, h} :
                 size == LDST_HU ? {16'b0, h} : word;
    end
endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: single-outstanding RISC-V load/store unit with misalignment trap and bus timeout.
// Ports: clk_i, rst_i (async, active-low); core side core_req_i/core_we_i/core_size_i/core_addr_i/
// core_wd_i in, core_rd_o/core_stall_o/misaligned_o/bus_err_o out; memory side via riscv_lsu_if.master.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [2:0]        core_size_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [31:0]       core_wd_i,
    output logic [31:0]       core_rd_o,
    output logic              core_stall_o,
    output logic              misaligned_o,
    output logic              bus_err_o,
    riscv_lsu_if.master       mem
);
    // Timeout fires in the TIMEOUT-th BUSY cycle; the counter holds the number of BUSY cycles already spent.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t            state, state_n;
    logic [7:0]        cnt;
    logic              we_q;
    logic [2:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wd_q;
    logic [31:0]       load_data;
    logic              accept, mis, start, busy, timeout;

    lsu_load_format u_fmt (
        .word   (mem.mem_rd_i),
        .off    (addr_q[1:0]),
        .size   (size_q),
        .result (load_data)
    );

    always_comb begin
        accept  = state == IDLE && core_req_i;
        mis     = is_misaligned(core_size_i, core_addr_i[1:0]);
        start   = accept && !mis;
        busy    = state == BUSY;
        timeout = busy && !mem.mem_ready_i && cnt == TO_LAST;
        // A ready arriving in the timeout cycle completes the access, so ready is tested first.
        state_n = start ? BUSY : (busy && (mem.mem_ready_i || timeout)) ? DONE : busy ? BUSY : IDLE;
        core_stall_o = start || busy;
    end

    assign mem.mem_req_o  = busy;
    assign mem.mem_we_o   = busy && we_q;
    assign mem.mem_be_o   = busy ? byte_en(size_q, addr_q[1:0]) : 4'b0000;
    assign mem.mem_addr_o = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem.mem_wd_o   = store_data(size_q, wd_q);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            cnt          <= '0;
            we_q         <= 1'b0;
            size_q       <= '0;
            addr_q       <= '0;
            wd_q         <= '0;
            core_rd_o    <= '0;
            misaligned_o <= 1'b0;
            bus_err_o    <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= busy ? cnt + 8'd1 : 8'd0;
            misaligned_o <= accept && mis;
            bus_err_o    <= timeout;
            if (start) begin
                we_q   <= core_we_i;
                size_q <= core_size_i;
                addr_q <= core_addr_i;
                wd_q   <= core_wd_i;
            end
            if (busy && mem.mem_ready_i) core_rd_o <= we_q ? 32'd0 : load_data;
            else if (timeout) core_rd_o <= 32'd0;
        end
    end
endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed self-checking bench for riscv_lsu (TIMEOUT=4).
// Inputs change on the falling edge; outputs are sampled 1 ns later, away from the rising edge.
module tb_riscv_lsu;
    import riscv_lsu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        core_req_i = 1'b0;
    logic        core_we_i = 1'b0;
    logic [2:0]  core_size_i = 3'd0;
    logic [31:0] core_addr_i = '0;
    logic [31:0] core_wd_i = '0;
    logic [31:0] core_rd_o;
    logic        core_stall_o, misaligned_o, bus_err_o;
    int          n_chk = 0;
    int          n_err = 0;

    riscv_lsu_if #(.ADDR_W(32)) mem_bus ();

    riscv_lsu #(.ADDR_W(32), .TIMEOUT(4)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_size_i  (core_size_i),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .misaligned_o (misaligned_o),
        .bus_err_o    (bus_err_o),
        .mem          (mem_bus.master)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Load completing in the n-th BUSY cycle; checks stall, lanes, address and the returned data.
    task automatic run_load(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] w,
                            input int n, input logic [31:0] be, input logic [31:0] exp);
        @(negedge clk_i);
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = sz; core_addr_i = a; mem_bus.mem_rd_i = w;
        #1 chk("ld_stall_req", 32'(core_stall_o), 1);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk_i);
            core_req_i = 1'b0;
            mem_bus.mem_ready_i = (i == n);
            #1 chk("ld_busy_req", 32'(mem_bus.mem_req_o), 1);
            chk("ld_busy_stall", 32'(core_stall_o), 1);
            if (i == 1) begin
                chk("ld_be", 32'(mem_bus.mem_be_o), be);
                chk("ld_addr", mem_bus.mem_addr_o, {a[31:2], 2'b00});
                chk("ld_we", 32'(mem_bus.mem_we_o), 0);
            end
        end
        @(negedge clk_i);
        mem_bus.mem_ready_i = 1'b0;
        #1 chk("ld_rd", core_rd_o, exp);
        chk("ld_done_stall", 32'(core_stall_o), 0);
        chk("ld_done_err", 32'(bus_err_o), 0);
        chk("ld_done_req", 32'(mem_bus.mem_req_o), 0);
    endtask

    task automatic mis_case(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] rd_hold);
        @(negedge clk_i);
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = sz; core_addr_i = a;
        #1 chk("mis_stall", 32'(core_stall_o), 0);
        chk("mis_req0", 32'(mem_bus.mem_req_o), 0);
        @(negedge clk_i);
        core_req_i = 1'b0;
        #1 chk("mis_flag", 32'(misaligned_o), 1);
        chk("mis_req1", 32'(mem_bus.mem_req_o), 0);
        chk("mis_rd_hold", core_rd_o, rd_hold);
        @(negedge clk_i);
        #1 chk("mis_pulse", 32'(misaligned_o), 0);
        chk("mis_req2", 32'(mem_bus.mem_req_o), 0);
    endtask

    initial begin
        mem_bus.mem_rd_i = '0;
        mem_bus.mem_ready_i = 1'b0;
        #2 rst_i = 1'b0;
        @(negedge clk_i);
        #1 chk("rst_req", 32'(mem_bus.mem_req_o), 0);
        chk("rst_stall", 32'(core_stall_o), 0);
        chk("rst_rd", core_rd_o, 0);
        chk("rst_be", 32'(mem_bus.mem_be_o), 0);
        chk("rst_flags", {30'd0, misaligned_o, bus_err_o}, 0);
        @(negedge clk_i);
        rst_i = 1'b1;

        run_load(LDST_B, 32'h103, 32'h80FF_1234, 2, 32'h8, 32'hFFFF_FF80);
        @(negedge clk_i);
        #1 chk("rd_hold_idle", core_rd_o, 32'hFFFF_FF80);

        mis_case(LDST_W, 32'h101, 32'hFFFF_FF80);
        mis_case(3'd3, 32'h0, 32'hFFFF_FF80);
        mis_case(LDST_HU, 32'h11, 32'hFFFF_FF80);

        // LHU timeout: ready never arrives.
        @(negedge clk_i);
        core_req_i = 1'b1; core_size_i = LDST_HU; core_addr_i = 32'h10;
        #1 chk("to_stall_req", 32'(core_stall_o), 1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk_i);
            core_req_i = 1'b0;
            #1 chk("to_busy_req", 32'(mem_bus.mem_req_o), 1);
            chk("to_busy_noerr", 32'(bus_err_o), 0);
        end
        @(negedge clk_i);
        #1 chk("to_err", 32'(bus_err_o), 1);
        chk("to_rd", core_rd_o, 0);
        chk("to_stall", 32'(core_stall_o), 0);
        chk("to_req_done", 32'(mem_bus.mem_req_o), 0);
        @(negedge clk_i);
        #1 chk("to_err_pulse", 32'(bus_err_o), 0);
        chk("to_idle_req", 32'(mem_bus.mem_req_o), 0);

        // SH 0x202; a request held during DONE must be ignored.
        @(negedge clk_i);
        core_req_i = 1'b1; core_we_i = 1'b1; core_size_i = LDST_H; core_addr_i = 32'h202; core_wd_i = 32'h0000_ABCD;
        #1 chk("sh_stall", 32'(core_stall_o), 1);
        @(negedge clk_i);
        core_req_i = 1'b0;
        #1 chk("sh_be", 32'(mem_bus.mem_be_o), 32'hC);
        chk("sh_wd", mem_bus.mem_wd_o, 32'hABCD_ABCD);
        chk("sh_addr", mem_bus.mem_addr_o, 32'h200);
        chk("sh_we", 32'(mem_bus.mem_we_o), 1);
        chk("sh_req", 32'(mem_bus.mem_req_o), 1);
        mem_bus.mem_ready_i = 1'b1;
        @(negedge clk_i);
        mem_bus.mem_ready_i = 1'b0; core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = LDST_W; core_addr_i = 32'h0;
        #1 chk("sh_rd", core_rd_o, 0);
        chk("sh_done_stall", 32'(core_stall_o), 0);
        chk("sh_done_we", 32'(mem_bus.mem_we_o), 0);
        chk("sh_done_be", 32'(mem_bus.mem_be_o), 0);
        @(negedge clk_i);
        core_req_i = 1'b0;
        #1 chk("done_req_ignored", 32'(mem_bus.mem_req_o), 0);

        // SB lane replication.
        @(negedge clk_i);
        core_req_i = 1'b1; core_we_i = 1'b1; core_size_i = LDST_B; core_addr_i = 32'h31; core_wd_i = 32'h1234_565A;
        @(negedge clk_i);
        core_req_i = 1'b0; core_we_i = 1'b0;
        #1 chk("sb_be", 32'(mem_bus.mem_be_o), 32'h2);
        chk("sb_wd", mem_bus.mem_wd_o, 32'h5A5A_5A5A);
        chk("sb_addr", mem_bus.mem_addr_o, 32'h30);
        mem_bus.mem_ready_i = 1'b1;
        @(negedge clk_i);
        mem_bus.mem_ready_i = 1'b0;

        run_load(LDST_H,  32'h2, 32'h8001_0000, 1, 32'hC, 32'hFFFF_8001);
        run_load(LDST_HU, 32'h6, 32'h8001_0000, 1, 32'hC, 32'h0000_8001);
        run_load(LDST_BU, 32'h1, 32'h1234_56F0, 3, 32'h2, 32'h0000_0056);
        run_load(LDST_W,  32'h8, 32'hDEAD_BEEF, 1, 32'hF, 32'hDEAD_BEEF);
        run_load(LDST_H,  32'h0, 32'h0000_7FFF, 1, 32'h3, 32'h0000_7FFF);
        // Ready in the timeout cycle wins.
        run_load(LDST_BU, 32'h0, 32'h0000_00F0, 4, 32'h1, 32'h0000_00F0);

        // Reset during the second BUSY cycle aborts the access at once.
        @(negedge clk_i);
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = LDST_W; core_addr_i = 32'h40; mem_bus.mem_rd_i = 32'h1234_5678;
        @(negedge clk_i);
        core_req_i = 1'b0;
        @(negedge clk_i);
        #1 chk("abort_busy2", 32'(mem_bus.mem_req_o), 1);
        #1 rst_i = 1'b0;
        #1 chk("abort_req", 32'(mem_bus.mem_req_o), 0);
        chk("abort_stall", 32'(core_stall_o), 0);
        chk("abort_rd", core_rd_o, 0);
        @(negedge clk_i);
        rst_i = 1'b1;
        run_load(LDST_W, 32'h40, 32'h1234_5678, 1, 32'hF, 32'h1234_5678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
